ofifo_drain: RTL and testbench
==============================

# ofifo_drain

Drain engine on the output side of the corelet. It pops psum vectors from the OFIFO and writes them into psum SRAM at consecutive addresses. In accumulate mode it instead performs a read-modify-write, adding each popped vector lane-wise to the vector already stored at that address. It is controlled by a start/done command handshake from the host-side controller in core.

## Interface
Parameters:
- col, 8, number of psum lanes per vector
- psum_bw, 16, width of one signed psum lane
- addr_bw, 11, psum SRAM address width

Ports:
- clk  in  1  single clock domain; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  command pulse; sampled only in IDLE
- acc_mode  in  1  selects the command mode (0 = overwrite, 1 = accumulate); sampled with start
- base_addr  in  addr_bw  first SRAM address; sampled with start
- num_vec  in  addr_bw  number of vectors to drain; sampled with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the command completes
- ofifo_valid  in  1  OFIFO head holds valid data
- ofifo_rd  out  1  pops the OFIFO head at the clock edge
- ofifo_dout  in  col*psum_bw  OFIFO head data; lane j occupies bits [psum_bw*j +: psum_bw]
- sram_cen  out  1  SRAM chip enable, active-low
- sram_wen  out  1  SRAM write enable, active-low
- sram_addr  out  addr_bw  SRAM address
- sram_d  out  col*psum_bw  SRAM write data
- sram_q  in  col*psum_bw  SRAM read data; valid one cycle after a read is issued

## Operation
- States: IDLE, DRAIN, ACC_RD, ACC_WR, DONE.
- Command registers: base, num_vec, acc_mode, and a vector counter cnt.
- IDLE, when start=1:
  - latch base, num_vec and acc_mode; clear cnt;
  - next state is DONE if num_vec=0; otherwise DRAIN (acc_mode=0) or ACC_RD (acc_mode=1).
- DRAIN, when ofifo_valid=1:
  - drive ofifo_rd=1, sram_cen=0, sram_wen=0, sram_addr=base+cnt, sram_d=ofifo_dout;
  - increment cnt;
  - go to DONE after the write with cnt=num_vec-1.
- ACC_RD, when ofifo_valid=1:
  - drive ofifo_rd=1, sram_cen=0, sram_wen=1, sram_addr=base+cnt;
  - capture ofifo_dout into hold_reg;
  - go to ACC_WR.
- ACC_WR (unconditional):
  - drive sram_cen=0, sram_wen=0, same address, sram_d = lane-wise sram_q + hold_reg;
  - increment cnt;
  - go to DONE on the last vector, otherwise back to ACC_RD.
- DONE: done=1 for one cycle, then IDLE.
- Behaviour on conditions:
  - ofifo_valid=0 in DRAIN or ACC_RD: no pop and no SRAM access; state and cnt hold.
  - start while busy: ignored.
- Arithmetic:
  - lanes are signed, psum_bw bits wide;
  - the sum wraps modulo 2^psum_bw, with no saturation.
  - sram_addr = (base+cnt) modulo 2^addr_bw, so addresses wrap past the top.
- Outputs are Mealy/combinational from the state, registers and ofifo_valid. When no access is made, the idle values are: ofifo_rd=0, sram_cen=1, sram_wen=1, sram_addr=0, sram_d=0.

## Timing
- Reset values:
  - state=IDLE, cnt=0, hold_reg=0;
  - busy=0, done=0, ofifo_rd=0, sram_cen=1, sram_wen=1, sram_addr=0, sram_d=0.
- Reset is asynchronous and takes effect immediately, including mid-command. Any partially written region is left as is. Vectors already popped are lost.
- A start sampled at edge T gives busy=1 from T onward. The first pop can occur in the cycle following T.
- Overwrite mode throughput is 1 vector/cycle. Accumulate mode is 1 vector per 2 cycles, which rules out any read-after-write hazard on the same address.
- done pulses in the cycle after the edge that performed the final write; busy is still high in that cycle.
- With continuous ofifo_valid and start at edge T, done=1 in these cycles:
  - overwrite mode: the cycle [T+num_vec, T+num_vec+1];
  - accumulate mode: the cycle [T+2*num_vec, T+2*num_vec+1].

## Structure
- Shared package: state enum, default parameter constants, and a lane-slice helper function.
- One sub-module, psum_lane_adder: col parallel signed psum_bw-bit wrapping adders. It is purely combinational and used in ACC_WR.

## Test plan
- Reset: assert reset mid-DRAIN after 2 writes -> all outputs return to their reset values asynchronously; a new start after release works normally.
- Overwrite: base=0x010, num_vec=4, OFIFO always valid, vector i with all lanes = i -> writes to 0x010..0x013 on 4 consecutive cycles; done exactly once, one cycle after the last write.
- Valid gaps: ofifo_valid pattern 1,0,0,1,1 with num_vec=3 -> no ofifo_rd and sram_cen=1 during the gap cycles; 3 writes at base..base+2.
- Accumulate: SRAM[5] lanes=100, num_vec=2, base=5, popped lanes 3 then -7 to addr 5/6 with SRAM[6]=0x7FFF -> SRAM[5]=103, SRAM[6]=0x7FF8; a second run with popped lane 1 onto 0x7FFF gives 0x8000 (wrap).
- num_vec=0 -> done the cycle after start, no SRAM or OFIFO activity. start asserted while busy -> ignored, and the count is unaffected.
- Address wrap: base=2046, num_vec=3 -> writes to addresses 2046, 2047, 0.

Source files
------------

// File: rtl/ofifo_drain_pkg.sv
// ofifo_drain_pkg: drain FSM states, default sizes and a lane-slice helper
package ofifo_drain_pkg;
  typedef enum logic [2:0] {IDLE, DRAIN, ACC_RD, ACC_WR, DONE} state_t;
  localparam int COL = 8;
  localparam int PSUM_BW = 16;
  localparam int ADDR_BW = 11;
  function automatic logic [PSUM_BW-1:0] lane(input logic [COL*PSUM_BW-1:0] v, input int j);
    return v[PSUM_BW*j +: PSUM_BW];
  endfunction
endpackage

// File: rtl/ofifo_drain_psum_lane_adder.sv
// psum_lane_adder: col parallel wrapping psum adders
// a_i, b_i: packed psum vectors; sum_o: lane-wise a+b modulo 2^psum_bw
module psum_lane_adder
  import ofifo_drain_pkg::*;
#(
  parameter int col = COL,
  parameter int psum_bw = PSUM_BW
) (
  input  logic [col*psum_bw-1:0] a_i,
  input  logic [col*psum_bw-1:0] b_i,
  output logic [col*psum_bw-1:0] sum_o
);
  for (genvar g = 0; g < col; g++) begin : g_lane
    assign sum_o[psum_bw*g +: psum_bw] = a_i[psum_bw*g +: psum_bw] + b_i[psum_bw*g +: psum_bw];
  end
endmodule

// File: rtl/ofifo_drain.sv
// ofifo_drain: pops OFIFO psum vectors into psum SRAM, overwrite or read-modify-write accumulate
// cmd: start/acc_mode/base_addr/num_vec in, busy/done out
// ofifo: ofifo_valid/ofifo_dout in, ofifo_rd out
// sram: sram_cen/sram_wen/sram_addr/sram_d out (enables active-low), sram_q in (1-cycle read latency)
module ofifo_drain
  import ofifo_drain_pkg::*;
#(
  parameter int col = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int addr_bw = ADDR_BW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     acc_mode,
  input  logic [addr_bw-1:0]       base_addr,
  input  logic [addr_bw-1:0]       num_vec,
  output logic                     busy,
  output logic                     done,
  input  logic                     ofifo_valid,
  output logic                     ofifo_rd,
  input  logic [col*psum_bw-1:0]   ofifo_dout,
  output logic                     sram_cen,
  output logic                     sram_wen,
  output logic [addr_bw-1:0]       sram_addr,
  output logic [col*psum_bw-1:0]   sram_d,
  input  logic [col*psum_bw-1:0]   sram_q
);
  localparam int W = col*psum_bw;
  state_t state_q, state_d;
  logic [addr_bw-1:0] base_q, base_d, num_q, num_d, cnt_q, cnt_d, addr;
  logic acc_q, acc_d, pop, wr, last;
  logic [W-1:0] hold_q, hold_d, sum;
  psum_lane_adder #(.col(col), .psum_bw(psum_bw)) u_add (.a_i(sram_q), .b_i(hold_q), .sum_o(sum));
  assign addr = base_q + cnt_q;
  assign last = cnt_q == num_q - 1'b1;
  assign pop  = (state_q == DRAIN || state_q == ACC_RD) && ofifo_valid;
  // acc_q separates the overwrite pop (write now) from the accumulate pop (read first)
  assign wr   = (pop && !acc_q) || state_q == ACC_WR;
  always_comb begin
    busy      = state_q != IDLE;
    done      = state_q == DONE;
    ofifo_rd  = pop;
    sram_cen  = !(pop || state_q == ACC_WR);
    sram_wen  = !wr;
    sram_addr = sram_cen ? '0 : addr;
    sram_d    = !wr ? '0 : state_q == ACC_WR ? sum : ofifo_dout;
  end
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    num_d   = num_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: if (start) begin
        base_d  = base_addr;
        num_d   = num_vec;
        acc_d   = acc_mode;
        cnt_d   = '0;
        state_d = num_vec == '0 ? DONE : acc_mode ? ACC_RD : DRAIN;
      end
      DRAIN: if (ofifo_valid) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = last ? DONE : DRAIN;
      end
      ACC_RD: if (ofifo_valid) begin
        hold_d  = ofifo_dout;
        state_d = ACC_WR;
      end
      ACC_WR: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = last ? DONE : ACC_RD;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      num_q   <= '0;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      num_q   <= num_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end
endmodule

// File: tb/tb_ofifo_drain.sv
// tb_ofifo_drain: scoreboard bench with OFIFO and psum SRAM models
module tb_ofifo_drain;
  import ofifo_drain_pkg::*;
  localparam int W = COL*PSUM_BW;
  localparam int OW = 5 + ADDR_BW + W;
  localparam logic [OW-1:0] RST_OUT = {5'b00011, {ADDR_BW{1'b0}}, {W{1'b0}}};
  logic clk = 0, reset = 0, start = 0, acc_mode = 0, ofifo_valid = 0;
  logic [ADDR_BW-1:0] base_addr = '0, num_vec = '0;
  logic [W-1:0] ofifo_dout = '0, sram_q = '0;
  logic busy, done, ofifo_rd, sram_cen, sram_wen;
  logic [ADDR_BW-1:0] sram_addr;
  logic [W-1:0] sram_d;
  logic [OW-1:0] outs;
  logic [W-1:0] mem [0:2047];
  logic [W-1:0] fifo_mem [0:63];
  int head = 0, tail = 0;
  int vectors = 0, miscompares = 0;
  logic pre_we = 0;
  logic [ADDR_BW-1:0] pre_addr = '0;
  logic [W-1:0] pre_data = '0;
  logic [ADDR_BW+W-1:0] exp_q [$];
  logic [ADDR_BW+W-1:0] e;

  ofifo_drain dut (
    .clk(clk), .reset(reset), .start(start), .acc_mode(acc_mode),
    .base_addr(base_addr), .num_vec(num_vec), .busy(busy), .done(done),
    .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd), .ofifo_dout(ofifo_dout),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_d(sram_d), .sram_q(sram_q)
  );

  assign outs = {busy, done, ofifo_rd, sram_cen, sram_wen, sram_addr, sram_d};
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (!sram_cen) begin
      if (!sram_wen) mem[sram_addr] <= sram_d;
      else sram_q <= mem[sram_addr];
    end
  end

  always @(posedge clk) if (ofifo_rd) head <= head + 1;

  function automatic logic [W-1:0] mkvec(input int b, input int s);
    logic [W-1:0] r;
    for (int j = 0; j < COL; j++) r[PSUM_BW*j +: PSUM_BW] = PSUM_BW'(b + s*j);
    return r;
  endfunction

  task automatic push_fifo(input logic [W-1:0] v);
    fifo_mem[tail] = v;
    tail++;
  endtask

  task automatic preload(input logic [ADDR_BW-1:0] a, input logic [W-1:0] v);
    @(negedge clk);
    pre_we = 1; pre_addr = a; pre_data = v;
    @(negedge clk);
    pre_we = 0;
  endtask

  task automatic do_start(input logic acc, input int a, input int n);
    @(negedge clk);
    start = 1; acc_mode = acc; base_addr = ADDR_BW'(a); num_vec = ADDR_BW'(n);
    ofifo_valid = 0;
  endtask

  task automatic cyc(input bit v, output bit w);
    @(negedge clk);
    start = 0;
    ofifo_valid = v && head != tail;
    ofifo_dout = head != tail ? fifo_mem[head] : '0;
    #1;
    w = !sram_cen && !sram_wen;
  endtask

  task automatic test_reset();
    bit wr;
    repeat (2) @(negedge clk);
    vectors++;
    if (outs !== RST_OUT) begin miscompares++; $display("FAIL reset_vals got %h want %h", outs, RST_OUT); end
    @(negedge clk) reset = 1;
    for (int i = 0; i < 4; i++) begin push_fifo(mkvec(16'h500 + i, 1)); exp_q.push_back({ADDR_BW'(32 + i), mkvec(16'h500 + i, 1)}); end
    do_start(0, 32, 4);
    for (int c = 0; c < 3; c++) begin
      cyc(1, wr);
      if (wr) begin
        vectors++;
        e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        if ({sram_addr, sram_d} !== e) begin miscompares++; $display("FAIL rst_write c=%0d got %h want %h", c, {sram_addr, sram_d}, e); end
      end
    end
    #1 reset = 0;
    #1;
    vectors++;
    if (outs !== RST_OUT) begin miscompares++; $display("FAIL async_reset got %h want %h", outs, RST_OUT); end
    vectors++;
    if (mem[33] !== mkvec(16'h501, 1)) begin miscompares++; $display("FAIL rst_partial got %h want %h", mem[33], mkvec(16'h501, 1)); end
    exp_q.delete();
    tail = head;
    @(negedge clk) reset = 1;
  endtask

  task automatic test_overwrite();
    bit wr;
    for (int i = 0; i < 4; i++) begin push_fifo(mkvec(i, 16'h100)); exp_q.push_back({ADDR_BW'(16 + i), mkvec(i, 16'h100)}); end
    do_start(0, 16, 4);
    for (int c = 0; c < 6; c++) begin
      cyc(1, wr);
      if (wr) begin
        vectors++;
        e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        if ({sram_addr, sram_d} !== e) begin miscompares++; $display("FAIL ov_write c=%0d got %h want %h", c, {sram_addr, sram_d}, e); end
      end
      vectors++;
      if ({done, wr, busy} !== {c == 4, c < 4, c <= 4}) begin
        miscompares++; $display("FAIL ov_timing c=%0d got done/wr/busy=%b%b%b want %b%b%b", c, done, wr, busy, c == 4, c < 4, c <= 4);
      end
    end
  endtask

  task automatic test_gaps();
    bit wr, a;
    bit pat [6] = '{1, 0, 0, 1, 1, 1};
    for (int i = 0; i < 3; i++) begin push_fifo(mkvec(16'h40 + i, 3)); exp_q.push_back({ADDR_BW'(48 + i), mkvec(16'h40 + i, 3)}); end
    do_start(0, 48, 3);
    for (int c = 0; c < 6; c++) begin
      cyc(pat[c], wr);
      a = c < 5 && pat[c];
      if (wr) begin
        vectors++;
        e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        if ({sram_addr, sram_d} !== e) begin miscompares++; $display("FAIL gap_write c=%0d got %h want %h", c, {sram_addr, sram_d}, e); end
      end
      vectors++;
      if ({ofifo_rd, sram_cen, done} !== {a, !a, c == 5}) begin
        miscompares++; $display("FAIL gap_ctrl c=%0d got rd/cen/done=%b%b%b want %b%b%b", c, ofifo_rd, sram_cen, done, a, !a, c == 5);
      end
    end
  endtask

  task automatic test_accumulate();
    bit wr;
    preload(5, mkvec(100, 1));
    preload(6, mkvec(16'h7FFF, 0));
    push_fifo(mkvec(3, 0));
    push_fifo(mkvec(-7, 0));
    exp_q.push_back({ADDR_BW'(5), mkvec(103, 1)});
    exp_q.push_back({ADDR_BW'(6), mkvec(16'h7FF8, 0)});
    do_start(1, 5, 2);
    for (int c = 0; c < 6; c++) begin
      cyc(1, wr);
      if (wr) begin
        vectors++;
        e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        if ({sram_addr, sram_d} !== e) begin miscompares++; $display("FAIL acc_write c=%0d got %h want %h", c, {sram_addr, sram_d}, e); end
      end
      vectors++;
      if ({ofifo_rd, wr, sram_cen, done} !== {c == 0 || c == 2, c == 1 || c == 3, c >= 4, c == 4}) begin
        miscompares++; $display("FAIL acc_timing c=%0d got rd/wr/cen/done=%b%b%b%b", c, ofifo_rd, wr, sram_cen, done);
      end
    end
    vectors++;
    if (lane(mem[6], 3) !== 16'h7FF8 || mem[5] !== mkvec(103, 1)) begin
      miscompares++; $display("FAIL acc_mem got %h %h want %h %h", mem[5], mem[6], mkvec(103, 1), mkvec(16'h7FF8, 0));
    end
    preload(7, mkvec(16'h7FFF, 0));
    push_fifo(mkvec(1, 0));
    exp_q.push_back({ADDR_BW'(7), mkvec(16'h8000, 0)});
    do_start(1, 7, 1);
    for (int c = 0; c < 4; c++) begin
      cyc(1, wr);
      if (wr) begin
        vectors++;
        e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        if ({sram_addr, sram_d} !== e) begin miscompares++; $display("FAIL acc_wrap c=%0d got %h want %h", c, {sram_addr, sram_d}, e); end
      end
      vectors++;
      if (done !== (c == 2)) begin miscompares++; $display("FAIL acc_wrap_done c=%0d got %b want %b", c, done, c == 2); end
    end
  endtask

  task automatic test_zero_and_busy();
    bit wr;
    push_fifo(mkvec(9, 9));
    do_start(0, 100, 0);
    for (int c = 0; c < 2; c++) begin
      cyc(1, wr);
      vectors++;
      if ({done, busy, ofifo_rd, sram_cen} !== {c == 0, c == 0, 1'b0, 1'b1}) begin
        miscompares++; $display("FAIL zero_cmd c=%0d got done/busy/rd/cen=%b%b%b%b want %b%b01", c, done, busy, ofifo_rd, sram_cen, c == 0, c == 0);
      end
    end
    vectors++;
    if (tail - head !== 1) begin miscompares++; $display("FAIL zero_nopop got %0d want 1", tail - head); end
    tail = head;
    for (int i = 0; i < 4; i++) push_fifo(mkvec(16'h60 + i, 5));
    for (int i = 0; i < 3; i++) exp_q.push_back({ADDR_BW'(64 + i), mkvec(16'h60 + i, 5)});
    do_start(0, 64, 3);
    for (int c = 0; c < 5; c++) begin
      cyc(1, wr);
      if (c == 0) begin start = 1; acc_mode = 1; base_addr = 11'h100; num_vec = 1; end
      if (wr) begin
        vectors++;
        e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        if ({sram_addr, sram_d} !== e) begin miscompares++; $display("FAIL busy_write c=%0d got %h want %h", c, {sram_addr, sram_d}, e); end
      end
      vectors++;
      if ({done, wr, busy} !== {c == 3, c < 3, c <= 3}) begin
        miscompares++; $display("FAIL busy_ignore c=%0d got done/wr/busy=%b%b%b want %b%b%b", c, done, wr, busy, c == 3, c < 3, c <= 3);
      end
    end
    tail = head;
  endtask

  task automatic test_wrap();
    bit wr;
    int adr [3] = '{2046, 2047, 0};
    for (int i = 0; i < 3; i++) begin push_fifo(mkvec(16'h7F0 + i, 17)); exp_q.push_back({ADDR_BW'(adr[i]), mkvec(16'h7F0 + i, 17)}); end
    do_start(0, 2046, 3);
    for (int c = 0; c < 5; c++) begin
      cyc(1, wr);
      if (wr) begin
        vectors++;
        e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        if ({sram_addr, sram_d} !== e) begin miscompares++; $display("FAIL wrap_write c=%0d got %h want %h", c, {sram_addr, sram_d}, e); end
      end
      vectors++;
      if ({done, wr} !== {c == 3, c < 3}) begin
        miscompares++; $display("FAIL wrap_timing c=%0d got done/wr=%b%b want %b%b", c, done, wr, c == 3, c < 3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_overwrite();
    test_gaps();
    test_accumulate();
    test_zero_and_busy();
    test_wrap();
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL sb_leftover got %0d want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
